// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the codec power-up configuration sequencer:
// FSM state encoding, the default register table and the codec bus address.
package codec_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READY,
        ST_REQ,
        ST_ACCEPT,
        ST_XFER,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } codec_cfg_state_e;

    localparam int CODEC_TABLE_LEN = 11;

    // Element 0 is the first word written after reset.
    localparam logic [0:CODEC_TABLE_LEN-1][15:0] CODEC_INIT_TABLE = {
        16'h0B19, 16'h047F, 16'h067F, 16'h0810, 16'h0C00, 16'h13FF,
        16'h0E13, 16'h1001, 16'h0A01, 16'h0017, 16'h0217
    };

    localparam logic [7:0] CODEC_I2C_ADDR = 8'h34;

    // Counter width able to hold 0..max_val, never narrower than one bit.
    function automatic int count_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/codec_cfg_seq_if.sv
// Request/response link between the configuration sequencer and the I2C master.
interface codec_cfg_seq_if #(
    parameter int DATA_W = 16
);
    logic              ack_i2c;
    logic              wr_rd;
    logic [7:0]        addr;
    logic [DATA_W-1:0] data_config;
    logic              busy;
    logic              nack;

    modport master (
        output ack_i2c, wr_rd, addr, data_config,
        input  busy, nack
    );

    modport slave (
        input  ack_i2c, wr_rd, addr, data_config,
        output busy, nack
    );
endinterface

// File: rtl/codec_cfg_rom.sv
// Constant configuration table lookup; words past the package table and
// indices past NUM_REGS read as zero.
module codec_cfg_rom
    import codec_cfg_pkg::*;
#(
    parameter int NUM_REGS = 11,
    parameter int DATA_W   = 16,
    localparam int IDX_W   = $clog2(NUM_REGS)
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] word
);

    localparam logic [IDX_W:0] DEPTH = (IDX_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0] rom_words [NUM_REGS];
    logic              in_range;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_word
        if (gi < CODEC_TABLE_LEN) begin : g_tab
            assign rom_words[gi] = DATA_W'(CODEC_INIT_TABLE[gi]);
        end else begin : g_pad
            assign rom_words[gi] = '0;
        end
    end

    assign in_range = ({1'b0, idx} < DEPTH);
    assign word     = in_range ? rom_words[idx] : '0;

endmodule

// File: rtl/codec_cfg_seq.sv
// Power-up configuration sequencer: writes each table word to the codec via
// the I2C master, retrying NACKed words up to MAX_RETRY times.
module codec_cfg_seq
    import codec_cfg_pkg::*;
#(
    parameter int          NUM_REGS  = 11,
    parameter int          DATA_W    = 16,
    parameter logic [7:0]  DEV_ADDR  = CODEC_I2C_ADDR,
    parameter int          MAX_RETRY = 3,
    localparam int         IDX_W     = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    codec_cfg_seq_if.master   i2c,
    output logic [IDX_W-1:0]  reg_idx,
    output logic              done_config,
    output logic              all_done,
    output logic              error
);

    localparam int                RETRY_W   = count_width(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REGS - 1);

    codec_cfg_state_e   state_reg;
    logic [IDX_W-1:0]   reg_idx_reg;
    logic [RETRY_W-1:0] retry_reg;
    logic               ack_reg;
    logic               done_reg;
    logic               all_done_reg;
    logic               error_reg;
    logic               nack_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            reg_idx_reg  <= '0;
            retry_reg    <= '0;
            ack_reg      <= 1'b0;
            done_reg     <= 1'b0;
            all_done_reg <= 1'b0;
            error_reg    <= 1'b0;
            nack_reg     <= 1'b0;
        end else begin
            ack_reg  <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: state_reg <= ST_READY;
                ST_READY: begin
                    // Another master may own the bus; request only once it is idle.
                    if (!i2c.busy) begin
                        state_reg <= ST_REQ;
                        ack_reg   <= 1'b1;
                    end
                end
                ST_REQ: state_reg <= ST_ACCEPT;
                ST_ACCEPT: begin
                    if (i2c.busy) state_reg <= ST_XFER;
                end
                ST_XFER: begin
                    // nack is only meaningful on the cycle busy drops.
                    if (!i2c.busy) begin
                        nack_reg  <= i2c.nack;
                        state_reg <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!nack_reg) begin
                        done_reg  <= 1'b1;
                        retry_reg <= '0;
                        if (reg_idx_reg == LAST_IDX) begin
                            all_done_reg <= 1'b1;
                            state_reg    <= ST_DONE;
                        end else begin
                            reg_idx_reg <= reg_idx_reg + 1'b1;
                            state_reg   <= ST_READY;
                        end
                    end else if (retry_reg < RETRY_MAX) begin
                        retry_reg <= retry_reg + 1'b1;
                        state_reg <= ST_READY;
                    end else begin
                        error_reg <= 1'b1;
                        state_reg <= ST_ERROR;
                    end
                end
                ST_DONE, ST_ERROR: begin
                    if (start) begin
                        all_done_reg <= 1'b0;
                        error_reg    <= 1'b0;
                        reg_idx_reg  <= '0;
                        retry_reg    <= '0;
                        state_reg    <= ST_READY;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    codec_cfg_rom #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W)
    ) u_rom (
        .idx  (reg_idx_reg),
        .word (i2c.data_config)
    );

    assign i2c.ack_i2c = ack_reg;
    assign i2c.wr_rd   = 1'b0;
    assign i2c.addr    = DEV_ADDR;
    assign reg_idx     = reg_idx_reg;
    assign done_config = done_reg;
    assign all_done    = all_done_reg;
    assign error       = error_reg;

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Scoreboard bench: an 11-word instance with a NACK-capable slave model and a
// 4-word instance whose busy line can be held high across reset release.
module tb_codec_cfg_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [15:0] word;
    } exp_t;

    logic [15:0] exp_words [11] = '{16'h0B19, 16'h047F, 16'h067F, 16'h0810,
                                    16'h0C00, 16'h13FF, 16'h0E13, 16'h1001,
                                    16'h0A01, 16'h0017, 16'h0217};

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- DUT A: default table ----------------
    logic       reset_a = 1'b1;
    logic       start_a = 1'b0;
    logic [3:0] reg_idx_a;
    logic       done_a, all_done_a, error_a;
    codec_cfg_seq_if #(.DATA_W(16)) bus_a ();

    codec_cfg_seq #(
        .NUM_REGS(11), .DATA_W(16), .DEV_ADDR(8'h34), .MAX_RETRY(3)
    ) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .i2c(bus_a),
        .reg_idx(reg_idx_a), .done_config(done_a), .all_done(all_done_a), .error(error_a)
    );

    // ---------------- DUT B: four-word table ----------------
    logic       reset_b = 1'b1;
    logic       start_b = 1'b0;
    logic [1:0] reg_idx_b;
    logic       done_b, all_done_b, error_b;
    logic       sb_busy_b = 1'b0;
    logic       force_busy_b = 1'b1;
    codec_cfg_seq_if #(.DATA_W(16)) bus_b ();

    codec_cfg_seq #(
        .NUM_REGS(4), .DATA_W(16), .DEV_ADDR(8'h34), .MAX_RETRY(3)
    ) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .i2c(bus_b),
        .reg_idx(reg_idx_b), .done_config(done_b), .all_done(all_done_b), .error(error_b)
    );

    // Slave A: busy rises 1 cycle after a request, holds 3 cycles, NACK per plan.
    int         cnt_a = 0;
    int         nack_cnt_a = 0;
    int         nack_word_a = -1;
    int         nack_limit_a = 0;
    logic [3:0] xfer_idx_a = '0;

    always @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            bus_a.busy <= 1'b0;
            bus_a.nack <= 1'b0;
            cnt_a      <= 0;
        end else begin
            bus_a.nack <= 1'b0;
            if (start_a) nack_cnt_a <= 0;
            if (cnt_a != 0) begin
                cnt_a <= cnt_a - 1;
                if (cnt_a == 1) begin
                    bus_a.busy <= 1'b0;
                    if (int'(xfer_idx_a) == nack_word_a && nack_cnt_a < nack_limit_a) begin
                        bus_a.nack <= 1'b1;
                        nack_cnt_a <= nack_cnt_a + 1;
                    end
                end
            end else if (bus_a.ack_i2c) begin
                bus_a.busy <= 1'b1;
                cnt_a      <= 3;
                xfer_idx_a <= reg_idx_a;
            end
        end
    end

    // Slave B: never NACKs; busy can be forced high by the bench.
    int cnt_b = 0;
    assign bus_b.busy = sb_busy_b | force_busy_b;
    assign bus_b.nack = 1'b0;

    always @(posedge clk or posedge reset_b) begin
        if (reset_b) begin
            sb_busy_b <= 1'b0;
            cnt_b     <= 0;
        end else if (cnt_b != 0) begin
            cnt_b <= cnt_b - 1;
            if (cnt_b == 1) sb_busy_b <= 1'b0;
        end else if (bus_b.ack_i2c) begin
            sb_busy_b <= 1'b1;
            cnt_b     <= 3;
        end
    end

    // Scoreboard monitors: every request pops one expected (index, word).
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int   ack_cnt_a = 0, done_cnt_a = 0, ack_cnt_b = 0, done_cnt_b = 0;

    always @(negedge clk) begin
        if (!reset_a) begin
            if (bus_a.ack_i2c === 1'b1) begin
                ack_cnt_a++;
                n_checks++;
                if (q_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL req_a: unexpected request idx=%0d data=%h, required no request",
                             reg_idx_a, bus_a.data_config);
                end else begin
                    e_a = q_a.pop_front();
                    if (int'(reg_idx_a) !== e_a.idx || bus_a.data_config !== e_a.word ||
                        bus_a.wr_rd !== 1'b0 || bus_a.addr !== 8'h34) begin
                        n_fail++;
                        $display("FAIL req_a: got idx=%0d data=%h wr_rd=%b addr=%h, required idx=%0d data=%h wr_rd=0 addr=34",
                                 reg_idx_a, bus_a.data_config, bus_a.wr_rd, bus_a.addr, e_a.idx, e_a.word);
                    end else begin
                        $display("req_a idx=%0d data=%h ok", reg_idx_a, bus_a.data_config);
                    end
                end
            end
            if (done_a === 1'b1) done_cnt_a++;
        end
    end

    always @(negedge clk) begin
        if (!reset_b) begin
            if (bus_b.ack_i2c === 1'b1) begin
                ack_cnt_b++;
                n_checks++;
                if (q_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL req_b: unexpected request idx=%0d data=%h, required no request",
                             reg_idx_b, bus_b.data_config);
                end else begin
                    e_b = q_b.pop_front();
                    if (int'(reg_idx_b) !== e_b.idx || bus_b.data_config !== e_b.word) begin
                        n_fail++;
                        $display("FAIL req_b: got idx=%0d data=%h, required idx=%0d data=%h",
                                 reg_idx_b, bus_b.data_config, e_b.idx, e_b.word);
                    end else begin
                        $display("req_b idx=%0d data=%h ok", reg_idx_b, bus_b.data_config);
                    end
                end
            end
            if (done_b === 1'b1) done_cnt_b++;
        end
    end

    task automatic push_a(input int first, input int last);
        exp_t x;
        for (int i = first; i <= last; i++) begin
            x.idx = i; x.word = exp_words[i];
            q_a.push_back(x);
        end
    endtask

    task automatic pulse_start_a();
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
    endtask

    task automatic wait_end_a(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (all_done_a || error_a) begin ok = 1'b1; break; end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (reg_idx_a !== 4'd0)  begin n_fail++; $display("FAIL rst_idx: got %0d required 0", reg_idx_a); end
        n_checks++; if (bus_a.ack_i2c !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b required 0", bus_a.ack_i2c); end
        n_checks++; if (done_a !== 1'b0)     begin n_fail++; $display("FAIL rst_done: got %b required 0", done_a); end
        n_checks++; if (all_done_a !== 1'b0) begin n_fail++; $display("FAIL rst_all_done: got %b required 0", all_done_a); end
        n_checks++; if (error_a !== 1'b0)    begin n_fail++; $display("FAIL rst_error: got %b required 0", error_a); end
        n_checks++; if (bus_a.data_config !== 16'h0B19) begin n_fail++; $display("FAIL rst_data: got %h required 0B19", bus_a.data_config); end
        n_checks++; if (bus_a.wr_rd !== 1'b0 || bus_a.addr !== 8'h34) begin n_fail++; $display("FAIL rst_const: got wr_rd=%b addr=%h required 0/34", bus_a.wr_rd, bus_a.addr); end
        n_checks++; if (reg_idx_b !== 2'd0 || bus_b.data_config !== 16'h0B19) begin n_fail++; $display("FAIL rst_b: got idx=%0d data=%h required 0/0B19", reg_idx_b, bus_b.data_config); end
        $display("test_reset done");
    endtask

    task automatic test_clean_run();
        bit ok; int a0, d0;
        a0 = ack_cnt_a; d0 = done_cnt_a;
        push_a(0, 10);
        @(negedge clk); reset_a = 1'b0;
        wait_end_a(300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL clean_timeout: got no end, required all_done"); end
        n_checks++; if (ack_cnt_a - a0 !== 11) begin n_fail++; $display("FAIL clean_acks: got %0d required 11", ack_cnt_a - a0); end
        n_checks++; if (done_cnt_a - d0 !== 11) begin n_fail++; $display("FAIL clean_dones: got %0d required 11", done_cnt_a - d0); end
        n_checks++; if (all_done_a !== 1'b1 || error_a !== 1'b0) begin n_fail++; $display("FAIL clean_flags: got all_done=%b error=%b required 1/0", all_done_a, error_a); end
        n_checks++; if (reg_idx_a !== 4'd10) begin n_fail++; $display("FAIL clean_idx: got %0d required 10", reg_idx_a); end
        repeat (10) @(negedge clk);
        n_checks++; if (ack_cnt_a - a0 !== 11 || all_done_a !== 1'b1) begin n_fail++; $display("FAIL clean_hold: got acks=%0d all_done=%b required 11/1", ack_cnt_a - a0, all_done_a); end
        n_checks++; if (q_a.size() != 0) begin n_fail++; $display("FAIL clean_queue: got %0d left required 0", q_a.size()); end
        $display("test_clean_run done");
    endtask

    task automatic test_nack_retry();
        bit ok; int a0, d0;
        nack_word_a = 4; nack_limit_a = 2;
        push_a(0, 4); push_a(4, 4); push_a(4, 10);
        a0 = ack_cnt_a; d0 = done_cnt_a;
        pulse_start_a();
        n_checks++; if (all_done_a !== 1'b0) begin n_fail++; $display("FAIL retry_clear: got all_done=%b required 0", all_done_a); end
        wait_end_a(300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL retry_timeout: got no end, required all_done"); end
        n_checks++; if (ack_cnt_a - a0 !== 13) begin n_fail++; $display("FAIL retry_acks: got %0d required 13", ack_cnt_a - a0); end
        n_checks++; if (done_cnt_a - d0 !== 11) begin n_fail++; $display("FAIL retry_dones: got %0d required 11", done_cnt_a - d0); end
        n_checks++; if (all_done_a !== 1'b1 || error_a !== 1'b0) begin n_fail++; $display("FAIL retry_flags: got all_done=%b error=%b required 1/0", all_done_a, error_a); end
        n_checks++; if (q_a.size() != 0) begin n_fail++; $display("FAIL retry_queue: got %0d left required 0", q_a.size()); end
        $display("test_nack_retry done");
    endtask

    task automatic test_nack_error();
        bit ok; int a0;
        nack_word_a = 2; nack_limit_a = 1000;
        push_a(0, 2); push_a(2, 2); push_a(2, 2); push_a(2, 2);
        a0 = ack_cnt_a;
        pulse_start_a();
        wait_end_a(300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL err_timeout: got no end, required error"); end
        n_checks++; if (error_a !== 1'b1 || all_done_a !== 1'b0) begin n_fail++; $display("FAIL err_flags: got error=%b all_done=%b required 1/0", error_a, all_done_a); end
        n_checks++; if (reg_idx_a !== 4'd2) begin n_fail++; $display("FAIL err_idx: got %0d required 2", reg_idx_a); end
        n_checks++; if (ack_cnt_a - a0 !== 6) begin n_fail++; $display("FAIL err_acks: got %0d required 6", ack_cnt_a - a0); end
        repeat (20) @(negedge clk);
        n_checks++; if (ack_cnt_a - a0 !== 6 || error_a !== 1'b1) begin n_fail++; $display("FAIL err_hold: got acks=%0d error=%b required 6/1", ack_cnt_a - a0, error_a); end
        n_checks++; if (q_a.size() != 0) begin n_fail++; $display("FAIL err_queue: got %0d left required 0", q_a.size()); end
        $display("test_nack_error done");
    endtask

    task automatic test_error_restart();
        bit ok, seen; int a0, d0;
        nack_word_a = -1; nack_limit_a = 0;
        push_a(0, 10);
        a0 = ack_cnt_a; d0 = done_cnt_a;
        pulse_start_a();
        n_checks++; if (error_a !== 1'b0) begin n_fail++; $display("FAIL restart_clear: got error=%b required 0", error_a); end
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (ack_cnt_a - a0 >= 3) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL restart_progress: got %0d acks required 3", ack_cnt_a - a0); end
        pulse_start_a();
        wait_end_a(300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL restart_timeout: got no end, required all_done"); end
        n_checks++; if (ack_cnt_a - a0 !== 11 || done_cnt_a - d0 !== 11) begin n_fail++; $display("FAIL restart_counts: got acks=%0d dones=%0d required 11/11", ack_cnt_a - a0, done_cnt_a - d0); end
        n_checks++; if (all_done_a !== 1'b1 || error_a !== 1'b0) begin n_fail++; $display("FAIL restart_flags: got all_done=%b error=%b required 1/0", all_done_a, error_a); end
        $display("test_error_restart done");
    endtask

    task automatic test_reset_mid_xfer();
        bit ok, seen; int a0;
        push_a(0, 10);
        pulse_start_a();
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (bus_a.ack_i2c === 1'b1 && reg_idx_a === 4'd6) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL midrst_reach: got idx=%0d required request for word 6", reg_idx_a); end
        repeat (2) @(negedge clk);
        reset_a = 1'b1;
        #1;
        n_checks++; if (reg_idx_a !== 4'd0 || bus_a.ack_i2c !== 1'b0 || done_a !== 1'b0) begin n_fail++; $display("FAIL midrst_regs: got idx=%0d ack=%b done=%b required 0/0/0", reg_idx_a, bus_a.ack_i2c, done_a); end
        n_checks++; if (all_done_a !== 1'b0 || error_a !== 1'b0 || bus_a.data_config !== 16'h0B19) begin n_fail++; $display("FAIL midrst_flags: got all_done=%b error=%b data=%h required 0/0/0B19", all_done_a, error_a, bus_a.data_config); end
        q_a.delete();
        push_a(0, 10);
        a0 = ack_cnt_a;
        @(negedge clk); reset_a = 1'b0;
        wait_end_a(300, ok);
        n_checks++; if (!ok || all_done_a !== 1'b1) begin n_fail++; $display("FAIL midrst_end: got all_done=%b required 1", all_done_a); end
        n_checks++; if (ack_cnt_a - a0 !== 11 || q_a.size() != 0) begin n_fail++; $display("FAIL midrst_acks: got %0d acks, %0d left required 11/0", ack_cnt_a - a0, q_a.size()); end
        $display("test_reset_mid_xfer done");
    endtask

    task automatic test_short_table();
        exp_t x; bit ok;
        for (int i = 0; i < 4; i++) begin x.idx = i; x.word = exp_words[i]; q_b.push_back(x); end
        @(negedge clk); reset_b = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++; if (ack_cnt_b !== 0 || reg_idx_b !== 2'd0) begin n_fail++; $display("FAIL short_hold: got acks=%0d idx=%0d required 0/0", ack_cnt_b, reg_idx_b); end
        force_busy_b = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (all_done_b || error_b) ok = 1'b1;
        end
        @(negedge clk);
        n_checks++; if (!ok || all_done_b !== 1'b1 || error_b !== 1'b0) begin n_fail++; $display("FAIL short_end: got all_done=%b error=%b required 1/0", all_done_b, error_b); end
        n_checks++; if (ack_cnt_b !== 4 || done_cnt_b !== 4) begin n_fail++; $display("FAIL short_counts: got acks=%0d dones=%0d required 4/4", ack_cnt_b, done_cnt_b); end
        n_checks++; if (reg_idx_b !== 2'd3) begin n_fail++; $display("FAIL short_idx: got %0d required 3", reg_idx_b); end
        repeat (10) @(negedge clk);
        n_checks++; if (ack_cnt_b !== 4 || q_b.size() != 0) begin n_fail++; $display("FAIL short_after: got acks=%0d left=%0d required 4/0", ack_cnt_b, q_b.size()); end
        $display("test_short_table done");
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_clean_run();
        test_nack_retry();
        test_nack_error();
        test_error_restart();
        test_reset_mid_xfer();
        test_short_table();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
